// File: rtl/sum_ram_drain.sv
// Sum RAM read-out: sweeps the RAM, requantizes each partial sum and
// streams it downstream through a credit-protected skid FIFO.
//
// Ports:
//   I_clk, I_rst         clock, async active-high reset
//   I_start              one-cycle pulse, samples I_depth / I_shift
//   I_depth, I_shift     word count and right-shift for this sweep
//   O_rd_en, O_raddr     RAM read port
//   I_rdata              RAM data, valid C_RD_LAT cycles after O_rd_en
//   O_dout, O_dout_valid requantized word at the FIFO head
//   I_dout_ready         downstream accept
//   O_busy, O_done       sweep in progress / one-cycle completion pulse
module sum_ram_drain #(
    parameter int C_DSIZE      = 24,
    parameter int C_OSIZE      = 8,
    parameter int C_ASIZE      = 10,
    parameter int C_RD_LAT     = 2,
    parameter int C_FIFO_DEPTH = 8
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_start,
    input  logic [C_ASIZE:0]   I_depth,
    input  logic [4:0]         I_shift,
    output logic               O_rd_en,
    output logic [C_ASIZE-1:0] O_raddr,
    input  logic [C_DSIZE-1:0] I_rdata,
    output logic [C_OSIZE-1:0] O_dout,
    output logic               O_dout_valid,
    input  logic               I_dout_ready,
    output logic               O_busy,
    output logic               O_done
);

    localparam int PW = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(C_FIFO_DEPTH + 1);
    localparam int LW = $clog2(C_RD_LAT + 1);
    localparam int OW = ((CW > LW) ? CW : LW) + 1;

    localparam logic signed [C_DSIZE:0] QMAX =
        (C_DSIZE + 1)'(2 ** (C_OSIZE - 1) - 1);
    localparam logic signed [C_DSIZE:0] QMIN =
        (C_DSIZE + 1)'(-(2 ** (C_OSIZE - 1)));
    localparam logic [4:0] SH_MAX = 5'(C_DSIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state;
    logic [C_ASIZE:0]   depth_q;
    logic [4:0]         shift_q;

    logic [C_RD_LAT-1:0] vpipe;
    logic                tap;
    logic [LW-1:0]       inflight;
    logic [OW-1:0]       occ;
    logic                issue;
    logic                last_issue;
    logic                drained;

    logic [C_OSIZE-1:0] mem [C_FIFO_DEPTH];
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic [CW-1:0]      cnt;
    logic               push;
    logic               pop;

    logic [4:0]                sh;
    logic signed [C_DSIZE:0]   s_ext;
    logic signed [C_DSIZE:0]   rnd;
    logic signed [C_DSIZE:0]   r;
    logic [C_OSIZE-1:0]        q;

    // Reads in flight plus words already buffered: this is the credit
    // that keeps the FIFO from ever overflowing.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < C_RD_LAT; i++) begin
            inflight = inflight + LW'(vpipe[i]);
        end
    end

    assign occ        = OW'(inflight) + OW'(cnt);
    assign issue      = (state == S_READ) && (occ < OW'(C_FIFO_DEPTH));
    assign last_issue = issue && ({1'b0, O_raddr} == depth_q - 1'b1);
    assign O_rd_en    = issue;

    assign tap  = vpipe[C_RD_LAT-1];
    assign push = tap;
    assign pop  = O_dout_valid && I_dout_ready;

    // Look ahead one cycle so O_done follows the last accept directly.
    assign drained = (vpipe == '0) &&
                     ((cnt == '0) || ((cnt == CW'(1)) && pop));

    // Sweep control
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state   <= S_IDLE;
            depth_q <= '0;
            shift_q <= '0;
            O_raddr <= '0;
            O_busy  <= 1'b0;
            O_done  <= 1'b0;
        end else begin
            O_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (I_start) begin
                        depth_q <= I_depth;
                        shift_q <= I_shift;
                        O_raddr <= '0;
                        O_busy  <= 1'b1;
                        if (I_depth == '0) begin
                            state  <= S_DONE;
                            O_done <= 1'b1;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (last_issue) begin
                        state <= S_FLUSH;
                    end else if (issue) begin
                        O_raddr <= O_raddr + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (drained) begin
                        state  <= S_DONE;
                        O_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    O_busy <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Read-latency tracker: a set bit at the tap marks valid I_rdata.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            vpipe <= '0;
        end else begin
            vpipe <= (vpipe << 1) | C_RD_LAT'(issue);
        end
    end

    // Round half up, arithmetic shift, saturate to C_OSIZE.
    always_comb begin
        sh    = (shift_q > SH_MAX) ? SH_MAX : shift_q;
        s_ext = {I_rdata[C_DSIZE-1], I_rdata};
        rnd   = '0;
        r     = s_ext;
        if (sh != 5'd0) begin
            rnd = (C_DSIZE + 1)'(1) << (sh - 5'd1);
            r   = (s_ext + rnd) >>> sh;
        end
        if (r > QMAX) begin
            q = QMAX[C_OSIZE-1:0];
        end else if (r < QMIN) begin
            q = QMIN[C_OSIZE-1:0];
        end else begin
            q = r[C_OSIZE-1:0];
        end
    end

    // Skid FIFO storage
    always_ff @(posedge I_clk) begin
        if (push) begin
            mem[wptr] <= q;
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == PW'(C_FIFO_DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == PW'(C_FIFO_DEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Show-ahead head; forced to zero when empty so reset leaves it at 0.
    assign O_dout_valid = (cnt != '0);
    assign O_dout       = O_dout_valid ? mem[rptr] : '0;

endmodule

// File: tb/tb_sum_ram_drain.sv
// Bench for sum_ram_drain: table of quantizer vectors plus directed
// sweeps (latency, backpressure, zero depth, abort, max depth).
module tb_sum_ram_drain;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] depth;
    logic [4:0]  shift;
    logic        rd_en;
    logic [9:0]  raddr;
    logic [23:0] rdata;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        done;

    sum_ram_drain dut (
        .I_clk        (clk),
        .I_rst        (rst),
        .I_start      (start),
        .I_depth      (depth),
        .I_shift      (shift),
        .O_rd_en      (rd_en),
        .O_raddr      (raddr),
        .I_rdata      (rdata),
        .O_dout       (dout),
        .O_dout_valid (dout_valid),
        .I_dout_ready (dout_ready),
        .O_busy       (busy),
        .O_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act,
                         input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // RAM model, two-cycle read latency
    logic [23:0] ram [1024];
    logic [23:0] p1;
    always @(posedge clk) begin
        p1    <= rd_en ? ram[raddr] : 24'h0;
        rdata <= p1;
    end

    // Ready driver: 0 = high, 1 = random ~30% low, 2 = held low
    int rmode = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: dout_ready = 1'b1;
            1: dout_ready = ($urandom_range(0, 99) >= 30);
            default: dout_ready = 1'b0;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    logic [7:0] got[$];
    int t0 = 0;
    int sweep_depth = 0;
    int issued, max_out, max_addr, addr_err, stab_err;
    int done_cnt, done_rel, first_rel, stall_seen;
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en) begin
                if (int'(raddr) != issued) addr_err++;
                issued++;
                if (int'(raddr) > max_addr) max_addr = int'(raddr);
            end
            if (busy && !done && !rd_en && issued < sweep_depth)
                stall_seen++;
            if (issued - got.size() > max_out)
                max_out = issued - got.size();
            if (pv && !pr && (!dout_valid || dout != pd)) stab_err++;
            if (dout_valid && first_rel < 0) first_rel = cyc - t0 + 1;
            if (dout_valid && dout_ready) got.push_back(dout);
            if (done) begin
                done_cnt++;
                done_rel = cyc - t0 + 1;
            end
            pv = dout_valid;
            pr = dout_ready;
            pd = dout;
        end
    end

    task automatic run_start(input int d, input int s);
        @(posedge clk);
        #1;
        got.delete();
        issued      = 0;
        max_out     = 0;
        max_addr    = -1;
        addr_err    = 0;
        stab_err    = 0;
        done_cnt    = 0;
        done_rel    = -1;
        first_rel   = -1;
        stall_seen  = 0;
        pv          = 1'b0;
        sweep_depth = d;
        start = 1'b1;
        depth = 11'(d);
        shift = 5'(s);
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        check($sformatf("%s_done_once", name), done_cnt, 1);
    endtask

    // Reference requantizer using floor division
    function automatic int quant(input logic [23:0] raw, input int sh);
        longint v;
        longint d;
        longint n;
        longint r;
        int     e;
        v = longint'($signed(raw));
        e = (sh > 23) ? 23 : sh;
        if (e == 0) begin
            r = v;
        end else begin
            d = longint'(1) << e;
            n = v + d / 2;
            r = n / d;
            if ((n % d) != 0 && n < 0) r = r - 1;
        end
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    task automatic check_data(input string name, input int d, input int s);
        int bad = 0;
        int lim;
        lim = (got.size() < d) ? got.size() : d;
        check($sformatf("%s_count", name), got.size(), d);
        for (int i = 0; i < lim; i++) begin
            if (int'($signed(got[i])) != quant(ram[i], s)) begin
                if (bad == 0)
                    $display("FAIL %s_word%0d: got %0d expected %0d", name,
                             i, $signed(got[i]), quant(ram[i], s));
                bad++;
            end
        end
        check($sformatf("%s_bad_words", name), bad, 0);
    endtask

    typedef struct {
        logic [23:0] data;
        int          sh;
        int          exp;
    } qvec_t;

    qvec_t tbl[18];

    initial begin
        tbl[0]  = '{24'h000018,  4,    2};
        tbl[1]  = '{24'hFFFFE8,  4,   -1};
        tbl[2]  = '{24'h000008,  4,    1};
        tbl[3]  = '{24'hFFFFF7,  4,   -1};
        tbl[4]  = '{24'h7FFFFF,  4,  127};
        tbl[5]  = '{24'h800000,  4, -128};
        tbl[6]  = '{24'h000005,  0,    5};
        tbl[7]  = '{24'h0000C8,  0,  127};
        tbl[8]  = '{24'hFFFF38,  0, -128};
        tbl[9]  = '{24'h000003,  1,    2};
        tbl[10] = '{24'hFFFFFD,  1,   -1};
        tbl[11] = '{24'h7FFFFF, 31,    1};
        tbl[12] = '{24'h800000, 31,   -1};
        tbl[13] = '{24'h000064,  7,    1};
        tbl[14] = '{24'hFFFFC0,  7,    0};
        tbl[15] = '{24'hFFFFBF,  7,   -1};
        tbl[16] = '{24'hFFFFF8,  4,    0};
        tbl[17] = '{24'h000017,  4,    1};

        rst        = 1'b1;
        start      = 1'b0;
        depth      = '0;
        shift      = '0;
        dout_ready = 1'b1;
        for (int i = 0; i < 1024; i++) ram[i] = 24'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {rd_en, raddr, dout, dout_valid, busy, done}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Quantizer vectors, one single-word sweep each
        for (int k = 0; k < 18; k++) begin
            ram[0] = tbl[k].data;
            run_start(1, tbl[k].sh);
            wait_done($sformatf("qvec%0d", k), 50);
            check($sformatf("qvec%0d_count", k), got.size(), 1);
            if (got.size() > 0)
                check($sformatf("qvec%0d_value", k),
                      int'($signed(got[0])), tbl[k].exp);
        end

        // T1: latency and back-to-back streaming
        for (int i = 0; i < 16; i++) ram[i] = 24'(i);
        rmode = 0;
        run_start(16, 0);
        wait_done("t1", 100);
        check_data("t1", 16, 0);
        check("t1_first_valid_cycle", first_rel, 4);
        check("t1_done_cycle", done_rel, 20);
        check("t1_addr_seq_errs", addr_err, 0);
        check("t1_max_addr", max_addr, 15);
        check("t1_busy_after", busy, 0);

        // T2: four-word sweep with hand-computed results
        ram[0] = 24'h000018;
        ram[1] = 24'hFFFFE8;
        ram[2] = 24'h000008;
        ram[3] = 24'hFFFFF7;
        run_start(4, 4);
        wait_done("t2", 100);
        check("t2_count", got.size(), 4);
        if (got.size() == 4) begin
            check("t2_w0", int'($signed(got[0])), 2);
            check("t2_w1", int'($signed(got[1])), -1);
            check("t2_w2", int'($signed(got[2])), 1);
            check("t2_w3", int'($signed(got[3])), -1);
        end

        // T3: backpressure, FIFO fills then random ready
        for (int i = 0; i < 64; i++) ram[i] = 24'(i * 1000 - 30000);
        rmode = 2;
        run_start(64, 6);
        repeat (12) @(posedge clk);
        rmode = 1;
        wait_done("t3", 2000);
        rmode = 0;
        check_data("t3", 64, 6);
        check("t3_max_outstanding", max_out, 8);
        check("t3_stall_seen", (stall_seen > 0) ? 1 : 0, 1);
        check("t3_stable_errs", stab_err, 0);
        check("t3_addr_seq_errs", addr_err, 0);

        // T4: zero depth
        run_start(0, 0);
        wait_done("t4_zero", 20);
        check("t4_zero_done_cycle", done_rel, 1);
        check("t4_zero_reads", issued, 0);
        check("t4_zero_valid", first_rel, -1);

        // T4: start while busy is ignored
        for (int i = 0; i < 8; i++) ram[i] = 24'(i * 3 + 1);
        run_start(8, 0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        depth = 11'd5;
        shift = 5'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t4_busy", 100);
        check_data("t4_busy", 8, 0);
        repeat (10) @(posedge clk);
        check("t4_busy_reads", issued, 8);
        check("t4_busy_done_count", done_cnt, 1);

        // T5: reset mid-sweep, then restart from address 0
        for (int i = 0; i < 32; i++) ram[i] = 24'(i + 100);
        run_start(32, 0);
        begin
            int n = 0;
            while (got.size() < 10 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("t5_reached_word10", (got.size() >= 10) ? 1 : 0, 1);
        end
        #2;
        rst = 1'b1;
        #1;
        check("t5_outputs_zero",
              {rd_en, raddr, dout, dout_valid, busy, done}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        check("t5_no_done", done_cnt, 0);
        run_start(4, 0);
        wait_done("t5_restart", 100);
        check_data("t5_restart", 4, 0);
        check("t5_addr_seq_errs", addr_err, 0);

        // T6: maximum depth
        for (int i = 0; i < 1024; i++) ram[i] = 24'(i * 37);
        run_start(1024, 3);
        wait_done("t6", 3000);
        check_data("t6", 1024, 3);
        check("t6_max_addr", max_addr, 1023);
        check("t6_done_cycle", done_rel, 1028);
        check("t6_addr_seq_errs", addr_err, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
